// File: rtl/reaction_round_ctrl_pkg.sv
// Shared types and constants for the reaction-round controller.
package reaction_round_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ARMED = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam int unsigned RMS_W             = 10;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// Button-mux / score-side signal bundle of the reaction-round controller.
interface reaction_round_ctrl_if;
  import reaction_round_ctrl_pkg::*;

  logic             Start;
  logic             F;
  logic             AnyPressed;
  logic [2:0]       S;
  logic [7:0]       TargetLed;
  logic [RMS_W-1:0] ReactionMs;
  logic             Busy;
  logic             Done;
  logic             Hit;
  logic             Miss;
  logic             FalseStart;

  modport master (
    output Start, F, AnyPressed,
    input  S, TargetLed, ReactionMs, Busy, Done, Hit, Miss, FalseStart
  );

  modport slave (
    input  Start, F, AnyPressed,
    output S, TargetLed, ReactionMs, Busy, Done, Hit, Miss, FalseStart
  );

endinterface

// File: rtl/reaction_round_ctrl_ms_tick_gen.sv
// Millisecond tick divider with synchronous clear; tick_o marks the last cycle of each ms.
module ms_tick_gen #(
  parameter int unsigned TICKS_PER_MS = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned     DIV_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_MS - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (clear_i || (div_q == DIV_LAST)) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = (div_q == DIV_LAST);

endmodule

// File: rtl/reaction_round_ctrl.sv
// One reaction-time round: random target and delay, armed LED, ms timing and outcome.
module reaction_round_ctrl
  import reaction_round_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned MAX_MS       = 999,
  parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  reaction_round_ctrl_if.slave bus
);

  localparam int unsigned      DLY_W   = $clog2(MIN_DELAY_MS + 1024);
  localparam logic [DLY_W-1:0] DLY_MIN = DLY_W'(MIN_DELAY_MS);
  localparam logic [RMS_W-1:0] MS_MAX  = RMS_W'(MAX_MS);
  localparam logic [RMS_W-1:0] MS_LAST = RMS_W'(MAX_MS - 1);

  state_e           state_q;
  logic [15:0]      lfsr_q;
  logic [DLY_W-1:0] delay_q;
  logic [RMS_W-1:0] ms_q;
  logic [2:0]       s_q;
  logic [7:0]       led_q;
  logic [RMS_W-1:0] rms_q;
  logic             busy_q;
  logic             done_q;
  logic             hit_q;
  logic             miss_q;
  logic             fs_q;

  logic tick;
  logic start_ok;
  logic arm_now;
  logic tick_clear;

  assign start_ok   = bus.Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign arm_now    = (state_q == ST_WAIT) && !bus.AnyPressed && tick &&
                      (delay_q == DLY_W'(1));
  // The divider restarts so each phase begins with a full millisecond.
  assign tick_clear = start_ok || arm_now;

  ms_tick_gen #(
    .TICKS_PER_MS (TICKS_PER_MS)
  ) u_ms_tick_gen (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .clear_i (tick_clear),
    .tick_o  (tick)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      delay_q <= '0;
      ms_q    <= '0;
      s_q     <= '0;
      led_q   <= '0;
      rms_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.Start) begin
            state_q <= ST_WAIT;
            s_q     <= lfsr_q[2:0];
            delay_q <= DLY_MIN + DLY_W'(lfsr_q[12:3]);
            rms_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            fs_q    <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (bus.AnyPressed) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fs_q    <= 1'b1;
            rms_q   <= '0;
          end else if (tick) begin
            delay_q <= delay_q - DLY_W'(1);
            if (delay_q == DLY_W'(1)) begin
              state_q <= ST_ARMED;
              led_q   <= 8'b1 << s_q;
              ms_q    <= '0;
            end
          end
        end

        ST_ARMED: begin
          // The target button outranks a simultaneous wrong-button press.
          if (bus.F || bus.AnyPressed) begin
            state_q <= ST_DONE;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hit_q   <= bus.F;
            miss_q  <= !bus.F;
            rms_q   <= ms_q;
          end else if (tick) begin
            ms_q <= ms_q + RMS_W'(1);
            if (ms_q == MS_LAST) begin
              state_q <= ST_DONE;
              led_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              miss_q  <= 1'b1;
              rms_q   <= MS_MAX;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.S          = s_q;
  assign bus.TargetLed  = led_q;
  assign bus.ReactionMs = rms_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.Hit        = hit_q;
  assign bus.Miss       = miss_q;
  assign bus.FalseStart = fs_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl: a timestamp-based round model checked every
// cycle, plus literal expectations for the seeded round and each outcome.
module tb_reaction_round_ctrl;

  localparam int T     = 4;
  localparam int MIN_D = 2;
  localparam int MAXMS = 20;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  reaction_round_ctrl_if bus_if ();

  reaction_round_ctrl #(
    .TICKS_PER_MS (T),
    .MIN_DELAY_MS (MIN_D),
    .MAX_MS       (MAXMS),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- round model ----------------
  // A round started on cycle c lights the LED on cycle c + delay*T + 1; an ARMED cycle k
  // after that has counted floor(k/T) whole milliseconds.
  logic [15:0] m_lfsr;
  bit          m_valid  = 1'b0;
  bit          m_active = 1'b0;
  int          n        = 0;
  int          m_armed_at;
  int          m_k;
  logic [2:0]  e_s;
  logic [7:0]  e_led;
  logic [9:0]  e_rms;
  logic        e_busy, e_done, e_hit, e_miss, e_fs;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic end_round(input int kind, input int ms);
    m_active = 1'b0;
    e_led    = 8'h00;
    e_busy   = 1'b0;
    e_done   = 1'b1;
    e_hit    = (kind == 0);
    e_miss   = (kind == 1);
    e_fs     = (kind == 2);
    e_rms    = 10'(ms);
  endtask

  always @(posedge Clock) begin
    if (Reset) begin
      m_lfsr   = 16'hACE1;
      m_active = 1'b0;
      m_valid  = 1'b1;
      e_s = '0; e_led = '0; e_rms = '0;
      e_busy = 1'b0; e_done = 1'b0; e_hit = 1'b0; e_miss = 1'b0; e_fs = 1'b0;
    end else begin
      if (m_active) begin
        if (n < m_armed_at) begin
          if (bus_if.AnyPressed) end_round(2, 0);
          else if (n == m_armed_at - 1) e_led = 8'(1 << e_s);
        end else begin
          m_k = n - m_armed_at;
          if (bus_if.F) end_round(0, m_k / T);
          else if (bus_if.AnyPressed) end_round(1, m_k / T);
          else if (m_k == MAXMS * T - 1) end_round(1, MAXMS);
        end
      end else if (bus_if.Start) begin
        m_active   = 1'b1;
        e_s        = m_lfsr[2:0];
        m_armed_at = n + (MIN_D + int'(m_lfsr[12:3])) * T + 1;
        e_led = '0; e_rms = '0;
        e_busy = 1'b1; e_done = 1'b0; e_hit = 1'b0; e_miss = 1'b0; e_fs = 1'b0;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    n++;
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      check("outputs", 32'({bus_if.S, bus_if.TargetLed, bus_if.ReactionMs, bus_if.Busy,
                            bus_if.Done, bus_if.Hit, bus_if.Miss, bus_if.FalseStart}),
                       32'({e_s, e_led, e_rms, e_busy, e_done, e_hit, e_miss, e_fs}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int k = 1);
    repeat (k) @(negedge Clock);
  endtask

  task automatic pulse_start();
    bus_if.Start = 1'b1;
    step();
    bus_if.Start = 1'b0;
  endtask

  task automatic press(input logic f, input logic any);
    bus_if.F          = f;
    bus_if.AnyPressed = any;
    step();
    bus_if.F          = 1'b0;
    bus_if.AnyPressed = 1'b0;
  endtask

  task automatic wait_armed(output int waited);
    waited = 0;
    while (bus_if.TargetLed == 8'h00 && waited < 5000) begin
      step();
      waited++;
    end
    check("armed_in_time", 32'(bus_if.TargetLed != 8'h00), 32'd1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus_if.S, bus_if.TargetLed, bus_if.ReactionMs, bus_if.Busy,
                bus_if.Done, bus_if.Hit, bus_if.Miss, bus_if.FalseStart});
  endfunction

  int waited;

  initial begin
    bus_if.Start = 1'b0; bus_if.F = 1'b0; bus_if.AnyPressed = 1'b0;
    step(3);
    check("por_outputs_zero", all_outs(), 32'd0);

    // Seeded round: target = 0xACE1[2:0] = 1, delay = 2 + 412 = 414 ms.
    Reset = 1'b0;
    pulse_start();
    check("seed_S", 32'(bus_if.S), 32'd1);
    check("seed_busy", 32'(bus_if.Busy), 32'd1);
    wait_armed(waited);
    check("seed_wait_cycles", 32'(waited), 32'd1656);
    check("seed_led", 32'(bus_if.TargetLed), 32'h02);
    step(28);
    press(1'b1, 1'b1);
    check("hit7_done", 32'({bus_if.Done, bus_if.Hit, bus_if.Miss, bus_if.FalseStart}), 32'b1100);
    check("hit7_ms", 32'(bus_if.ReactionMs), 32'd7);
    check("hit7_led_off", 32'(bus_if.TargetLed), 32'd0);

    // Wrong button at 5 ms, then target plus wrong button at 5 ms.
    pulse_start();
    check("restart_clears", 32'({bus_if.Busy, bus_if.Done, bus_if.Hit}), 32'b100);
    wait_armed(waited);
    step(20);
    press(1'b0, 1'b1);
    check("miss5_flags", 32'({bus_if.Done, bus_if.Hit, bus_if.Miss, bus_if.FalseStart}), 32'b1010);
    check("miss5_ms", 32'(bus_if.ReactionMs), 32'd5);
    pulse_start();
    wait_armed(waited);
    step(20);
    press(1'b1, 1'b1);
    check("hit5_flags", 32'({bus_if.Done, bus_if.Hit, bus_if.Miss}), 32'b110);
    check("hit5_ms", 32'(bus_if.ReactionMs), 32'd5);

    // Timeout with no press.
    pulse_start();
    wait_armed(waited);
    step(79);
    check("pre_timeout_armed", 32'({bus_if.Done, bus_if.Busy}), 32'b01);
    step();
    check("timeout_flags", 32'({bus_if.Done, bus_if.Hit, bus_if.Miss, bus_if.FalseStart}), 32'b1010);
    check("timeout_ms", 32'(bus_if.ReactionMs), 32'd20);
    check("timeout_led", 32'(bus_if.TargetLed), 32'd0);

    // Start ignored while busy; accepted in DONE.
    pulse_start();
    step(2);
    pulse_start();
    check("start_in_wait_busy", 32'({bus_if.Busy, bus_if.Done}), 32'b10);
    wait_armed(waited);
    step(3);
    pulse_start();
    check("start_in_armed_lit", 32'(bus_if.TargetLed != 8'h00), 32'd1);
    step(4);
    press(1'b1, 1'b0);
    check("hit2_ms", 32'(bus_if.ReactionMs), 32'd2);
    pulse_start();
    check("done_restart", 32'({bus_if.Busy, bus_if.Done, bus_if.Hit, bus_if.ReactionMs}), 32'h1000);

    // False start mid-WAIT, then button held through Start.
    step(2);
    press(1'b0, 1'b1);
    check("fs_flags", 32'({bus_if.Done, bus_if.Hit, bus_if.Miss, bus_if.FalseStart}), 32'b1001);
    check("fs_ms_led", 32'({bus_if.ReactionMs, bus_if.TargetLed}), 32'd0);
    bus_if.AnyPressed = 1'b1;
    pulse_start();
    step();
    bus_if.AnyPressed = 1'b0;
    check("held_fs", 32'({bus_if.Done, bus_if.FalseStart}), 32'b11);

    // Reset while ARMED, then a fresh start sees the seed again.
    pulse_start();
    wait_armed(waited);
    step(3);
    Reset = 1'b1;
    step();
    check("reset_mid_armed", all_outs(), 32'd0);
    Reset = 1'b0;
    pulse_start();
    check("reseed_S", 32'(bus_if.S), 32'd1);

    // Press on the very cycle the 414 ms delay expires: false start wins.
    step(1655);
    check("expiry_led_dark", 32'(bus_if.TargetLed), 32'd0);
    press(1'b0, 1'b1);
    check("expiry_fs", 32'({bus_if.Done, bus_if.FalseStart, bus_if.Hit, bus_if.Miss}), 32'b1100);
    check("expiry_led", 32'(bus_if.TargetLed), 32'd0);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_round_ctrl.md
Name: reaction_round_ctrl

Overview:
Sequences one reaction-time round by driving the select lines of the 8:1 button mux (S2..S0) and watching its output F. It picks a pseudo-random target and waits a random delay. It then lights the target LED, measures reaction time in milliseconds, and classifies the outcome as hit, miss, timeout or false start. It sits between the button synchroniser/mux datapath and the score/display logic.

Parameters:
TICKS_PER_MS, 50000, Clock cycles per 1 ms tick (50 MHz board clock).
MIN_DELAY_MS, 1000, fixed part of the pre-target delay in ms.
MAX_MS, 999, reaction window in ms; also the saturation value of ReactionMs.
LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be non-zero.

Ports:
Clock  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  one-cycle request to begin a round.
F  input  1  8:1 mux output: state of the currently selected button, active-high, already synchronised.
AnyPressed  input  1  OR of all 8 synchronised buttons.
S  output  3  mux select {S2,S1,S0}; equals the target index.
TargetLed  output  8  one-hot target LED, lit only in ARMED.
ReactionMs  output  10  measured reaction time; held until the next Start.
Busy  output  1  high in WAIT and ARMED.
Done  output  1  high in DONE.
Hit, Miss, FalseStart  output  1 each  result flags, valid while Done=1; exactly one is high.

Behaviour:
- Reset, synchronous and sampled on the Clock edge:
  - state=IDLE; S=0; TargetLed=0; ReactionMs=0.
  - Busy=Done=Hit=Miss=FalseStart=0.
  - LFSR=LFSR_SEED; tick divider=0; counters=0.
  - Reset mid-round aborts the round with no result.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every non-reset cycle, free-running regardless of state.
- ms tick:
  - Divider counts 0..TICKS_PER_MS-1, then wraps.
  - tick=1 on the cycle the divider equals TICKS_PER_MS-1.
  - Divider is cleared on entry to WAIT and on entry to ARMED.
- States: IDLE, WAIT, ARMED, DONE.
  - IDLE: outputs at reset values. Start -> WAIT.
  - DONE: Done held. Start -> WAIT.
  - Start is ignored while Busy.
- On the cycle Start is accepted:
  - target = LFSR[2:0]; S = target.
  - delay_ms = MIN_DELAY_MS + LFSR[12:3], giving 0..1023 ms of random extension.
  - Clear ReactionMs and all result flags; Done=0.
- WAIT:
  - delay_ms decrements on each tick; TargetLed=0.
  - AnyPressed=1 in any WAIT cycle -> DONE with FalseStart=1 and ReactionMs=0. This includes the first WAIT cycle, so a button held through Start is a false start.
  - delay_ms reaching 0 on a tick -> ARMED: TargetLed = 1<<target; ms counter=0.
  - If AnyPressed and delay expiry coincide, FalseStart wins.
- ARMED:
  - ms counter increments on each tick.
  - F=1 -> DONE, Hit=1, ReactionMs = ms counter; the press is registered that cycle.
  - AnyPressed=1 with F=0 (wrong button) -> DONE, Miss=1, ReactionMs = ms counter.
  - F has priority over a simultaneous wrong-button press.
  - ms counter reaching MAX_MS with no press -> DONE, Miss=1, ReactionMs=MAX_MS.
  - Leaving ARMED clears TargetLed.
- Latency:
  - Button edge at F -> Done=1 on the next Clock edge, one registered cycle.
  - All outputs are registered.
- S changes only on an accepted Start and is stable through WAIT, ARMED and DONE, so the mux path has settled before ARMED.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, WAIT=2'd1, ARMED=2'd2, DONE=2'd3)
  - LFSR_SEED and LFSR tap constants
  - ReactionMs width (10)
- One natural sub-module: ms_tick_gen. Holds the divider with a synchronous clear input and a tick output, parameterised by TICKS_PER_MS, and is reusable by the display blanking logic.
- The LFSR stays inline.

Test Plan:
Run all scenarios with TICKS_PER_MS=4, MIN_DELAY_MS=2 and MAX_MS=20 for simulation speed.
1. Reset mid-ARMED -> next cycle: state IDLE, S=0, TargetLed=0, ReactionMs=0, all flags 0, LFSR=16'hACE1.
2. Start from reset with the seed -> S=LFSR[2:0] captured on the Start cycle. TargetLed goes one-hot after (2+LFSR[12:3]) ticks. Driving F=1 after 7 ticks in ARMED -> Done=1, Hit=1, ReactionMs=7.
3. AnyPressed=1 during WAIT, including the cycle coinciding with delay expiry -> Done=1, FalseStart=1, ReactionMs=0; TargetLed never lit.
4. ARMED with AnyPressed=1 and F=0 at tick 5 -> Miss=1, ReactionMs=5. The same cycle with F=1 as well -> Hit=1.
5. ARMED with no press -> after 20 ticks Done=1, Miss=1, ReactionMs=20, TargetLed=0.
6. Start pulsed during WAIT and ARMED -> ignored (S and delay unchanged). Start in DONE -> new round begins and the previous flags clear the same edge.
